bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 32-bit system bus between the CPU datapath and memory/peripherals. It accepts read/write requests from NREQ masters, such as instruction fetch, data port and debug/DMA port. It grants exactly one master at a time and drives the bus slave interface. It returns a one-cycle completion handshake, or a timeout error if the slave never answers.

---
 rtl/bus_defs_pkg.sv | 30 +++
 rtl/rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_defs_pkg.sv
// Shared definitions for the system bus arbiter: FSM state encoding, size limits
// and one-hot/index conversion helpers.
package bus_defs;

  localparam int DW_DEFAULT = 32;
  localparam int NREQ_MAX   = 8;
  localparam int IDX_W      = $clog2(NREQ_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [NREQ_MAX-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ_MAX-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester found at or after ptr,
// wrapping modulo NREQ, wins.
module rr_pick
  import bus_defs::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  logic [PW-1:0] widx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    widx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        widx  = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;
  assign win = any ? NREQ'(idx_to_onehot(IDX_W'(widx))) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared system bus: grants one master,
// holds the latched transfer on the slave side, and returns ack or a timeout error.
module bus_arbiter
  import bus_defs::*;
#(
  parameter int NREQ    = 3,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   addr_i,
  input  logic [NREQ*DW-1:0]   wdata_i,
  input  logic [NREQ-1:0]      we_i,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 bus_en,
  output logic                 bus_we,
  output logic [DW-1:0]        bus_addr,
  output logic [DW-1:0]        bus_wdata,
  input  logic [DW-1:0]        bus_rdata,
  input  logic                 bus_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]  cnt;
  logic [NREQ-1:0] win;
  logic           any;
  logic           grant, done;
  logic [DW-1:0]  sel_addr, sel_wdata;
  logic           sel_we;
  logic [IDX_W-1:0] gnt_idx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        sel_addr  = addr_i[k*DW +: DW];
        sel_wdata = wdata_i[k*DW +: DW];
        sel_we    = we_i[k];
      end
    end
  end

  // A transfer ends on slave ready or on the last allowed wait cycle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus_ready || (cnt == CNT_MAX)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_idx = onehot_to_idx(NREQ_MAX'(gnt));
  assign ptr_nxt = (int'(gnt_idx) == NREQ - 1) ? '0 : PW'(int'(gnt_idx) + 1);

  assign bus_en = (state == BUSY);
  assign ack    = done ? gnt : '0;
  assign err    = done & ~bus_ready;
  assign rdata  = (done && bus_ready) ? bus_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt       <= win;
        bus_we    <= sel_we;
        bus_addr  <= sel_addr;
        bus_wdata <= sel_wdata;
        cnt       <= '0;
      end else if (done) begin
        gnt <= '0;
        ptr <= ptr_nxt;
      end else if ((state == BUSY) && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// checked against a distance-based round-robin reference model.
module tb_bus_arbiter;

  localparam int NREQ    = 3;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int BW      = NREQ + 2 + 2*DW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  addr_i, wdata_i;
  logic [NREQ-1:0]     we_i;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic [DW-1:0]       rdata;
  logic [NREQ-1:0]     gnt;
  logic                bus_en, bus_we;
  logic [DW-1:0]       bus_addr, bus_wdata, bus_rdata;
  logic                bus_ready;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int m_ptr = 0;
  int last_ack_cyc = 0;

  bus_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .ack(ack), .err(err), .rdata(rdata), .gnt(gnt),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Winner is the requester with the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = NREQ;
    for (int k = 0; k < NREQ; k++) begin
      d = (k - p + NREQ) % NREQ;
      if (r[k] && d < bestd) begin
        best  = k;
        bestd = d;
      end
    end
    return best;
  endfunction

  // ready_at: BUSY cycle carrying bus_ready (0 or beyond TIMEOUT means never).
  task automatic do_transfer(input logic [NREQ-1:0] rmask, input int ready_at,
                             input logic [NREQ*DW-1:0] a, input logic [NREQ*DW-1:0] d,
                             input logic [NREQ-1:0] w, input logic [DW-1:0] rd_val);
    int win, done_at;
    logic [NREQ-1:0] oh;
    logic [BW-1:0] exp_bus;
    logic [NREQ+1+DW-1:0] exp_resp;
    win     = model_pick(rmask, m_ptr);
    done_at = (ready_at >= 1 && ready_at <= TIMEOUT) ? ready_at : TIMEOUT;
    oh      = '0;
    oh[win] = 1'b1;
    exp_bus = {oh, 1'b1, w[win], a[win*DW +: DW], d[win*DW +: DW]};
    req = rmask; addr_i = a; wdata_i = d; we_i = w; bus_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= done_at; c++) begin
      if (c == 1) begin
        req     = rmask & ~oh;
        addr_i  = ~a;
        wdata_i = ~d;
        we_i    = ~w;
      end
      bus_ready = (c == ready_at);
      bus_rdata = (c == ready_at) ? rd_val : $urandom;
      #1;
      nvec++;
      if ({gnt, bus_en, bus_we, bus_addr, bus_wdata} !== exp_bus) begin
        nerr++;
        $display("[TB] FAIL busy_regs c=%0d: got %h expected %h", c,
                 {gnt, bus_en, bus_we, bus_addr, bus_wdata}, exp_bus);
      end
      if (c == done_at)
        exp_resp = {oh, (c != ready_at), (c == ready_at) ? rd_val : {DW{1'b0}}};
      else
        exp_resp = '0;
      nvec++;
      if ({ack, err, rdata} !== exp_resp) begin
        nerr++;
        $display("[TB] FAIL response c=%0d: got %h expected %h", c, {ack, err, rdata}, exp_resp);
      end
      if (c == done_at) last_ack_cyc = cyc;
      if (c < done_at) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req = '0; bus_ready = 1'b0;
    #1;
    nvec++;
    if ({gnt, bus_en, ack} !== '0) begin
      nerr++;
      $display("[TB] FAIL idle_after: got %h expected 0", {gnt, bus_en, ack});
    end
    m_ptr = (win + 1) % NREQ;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; addr_i = '0; wdata_i = '0; we_i = '0;
    bus_rdata = 32'hFFFF_FFFF; bus_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({gnt, bus_en, bus_we, bus_addr, bus_wdata, ack, err, rdata} !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_state: got %h expected 0",
               {gnt, bus_en, bus_we, bus_addr, bus_wdata, ack, err, rdata});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if ({gnt, bus_en, ack, err, rdata} !== '0) begin
      nerr++;
      $display("[TB] FAIL idle_ready_ignored: got %h expected 0", {gnt, bus_en, ack, err, rdata});
    end
    bus_ready = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single_read();
    logic [NREQ*DW-1:0] a;
    a = '0;
    a[1*DW +: DW] = 32'h0000_0040;
    do_transfer(3'b010, 1, a, '0, 3'b000, 32'hDEAD_BEEF);
  endtask

  task automatic test_round_robin();
    int prev;
    for (int t = 0; t < 4; t++) begin
      prev = last_ack_cyc;
      do_transfer(3'b111, 1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                  3'($urandom), $urandom);
      if (t > 0) begin
        nvec++;
        if (last_ack_cyc - prev != 2) begin
          nerr++;
          $display("[TB] FAIL rr_spacing: got %0d expected 2", last_ack_cyc - prev);
        end
      end
    end
  endtask

  task automatic test_wait_write();
    logic [NREQ*DW-1:0] a, d;
    a = {$urandom, $urandom, 32'h0000_0010};
    d = {$urandom, $urandom, 32'h1234_5678};
    do_transfer(3'b001, 3, a, d, 3'b001, $urandom);
  endtask

  task automatic test_timeout();
    do_transfer(3'b100, 0, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                3'b000, $urandom);
    do_transfer(3'b001, 2, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                3'b000, $urandom);
    do_transfer(3'b010, TIMEOUT, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                3'b000, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    do_transfer(3'b001, 1, '0, '0, 3'b000, $urandom);
    req = 3'b110; addr_i = {$urandom, $urandom, $urandom}; we_i = 3'b111;
    wdata_i = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bus_ready = 1'b0;
    #1;
    nvec++;
    if (ack !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_mid_ack: got %b expected 000", ack);
    end
    @(posedge clk); #1;
    nvec++;
    if ({gnt, bus_en, bus_we, bus_addr, bus_wdata, ack, err, rdata} !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_mid_state: got %h expected 0",
               {gnt, bus_en, bus_we, bus_addr, bus_wdata, ack, err, rdata});
    end
    rst = 1'b0; req = '0;
    m_ptr = 0;
    do_transfer(3'b111, 1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                3'b000, $urandom);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      do_transfer(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, TIMEOUT + 3),
                  {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                  NREQ'($urandom), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
